// File: rtl/punc_mem_arbiter_if.sv
// Bus bundle between the three requesters, the single-port memory and the arbiter.
// The arbiter uses the slave modport; requesters plus memory use the master modport.
interface punc_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              g_req;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              f_gnt;
  logic              d_gnt;
  logic              g_gnt;
  logic              rvalid;
  logic [1:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_w_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata,
    input  g_req, g_we, g_addr, g_wdata, mem_rdata,
    output f_gnt, d_gnt, g_gnt, rvalid, rid, rdata,
    output mem_addr, mem_wdata, mem_w_en, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata,
    output g_req, g_we, g_addr, g_wdata, mem_rdata,
    input  f_gnt, d_gnt, g_gnt, rvalid, rid, rdata,
    input  mem_addr, mem_wdata, mem_w_en, busy
  );
endinterface

// File: rtl/punc_mem_arbiter.sv
// Three-way single-port memory arbiter: data > fetch > debug, with a starvation escape for debug.
// States: IDLE arbitrate and latch | ACCESS drive memory, pulse gnt | RESP return read data.
module punc_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  punc_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int GW_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [GW_W-1:0] G_MAX = GW_W'(STARVE_LIMIT);

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_F    = 2'd1;
  localparam logic [1:0] ID_D    = 2'd2;
  localparam logic [1:0] ID_G    = 2'd3;

  state_t            state_q, state_d;
  logic [1:0]        id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [GW_W-1:0]   g_wait_q, g_wait_d;
  logic [1:0]        win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      id_q     <= ID_NONE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      g_wait_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      g_wait_q <= g_wait_d;
    end
  end

  // Winner selection is only consumed in IDLE; the starved debug port jumps the queue.
  always_comb begin
    win = ID_NONE;
    if (bus.g_req && (g_wait_q == G_MAX)) win = ID_G;
    else if (bus.d_req)                   win = ID_D;
    else if (bus.f_req)                   win = ID_F;
    else if (bus.g_req)                   win = ID_G;
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    g_wait_d = g_wait_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.g_req)              g_wait_d = '0;
        else if (win == ID_G)        g_wait_d = '0;
        else if (g_wait_q != G_MAX)  g_wait_d = g_wait_q + GW_W'(1);
        if (win != ID_NONE) begin
          state_d = ACCESS;
          id_d    = win;
          unique case (win)
            ID_D: begin
              addr_d  = bus.d_addr;
              we_d    = bus.d_we;
              wdata_d = bus.d_wdata;
            end
            ID_G: begin
              addr_d  = bus.g_addr;
              we_d    = bus.g_we;
              wdata_d = bus.g_wdata;
            end
            default: begin
              addr_d  = bus.f_addr;
              we_d    = 1'b0;
              wdata_d = '0;
            end
          endcase
        end
      end
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.f_gnt     = (state_q == ACCESS) && (id_q == ID_F);
  assign bus.d_gnt     = (state_q == ACCESS) && (id_q == ID_D);
  assign bus.g_gnt     = (state_q == ACCESS) && (id_q == ID_G);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_w_en  = (state_q == ACCESS) && we_q;
  assign bus.rvalid    = (state_q == RESP);
  assign bus.rid       = (state_q == RESP) ? id_q : ID_NONE;
  assign bus.rdata     = (state_q == RESP) ? bus.mem_rdata : '0;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Bench for punc_mem_arbiter: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level schedule model of the arbiter.
module tb_punc_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int nstep = 0;

  punc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  punc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [DW-1:0] mem   [0:65535];
  logic [DW-1:0] m_mem [0:65535];

  always @(posedge clk) begin
    if (bus.mem_w_en) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Schedule model: each arbitration at the end of a free cycle c books a grant in c+1,
  // read data in c+2, and frees the bus at c+2 (write) or c+3 (read).
  int            cyc = 0;
  int            next_idle = 0;
  int            gwait_m = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;
  bit            wr_pend = 0;
  int            wr_cyc = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [2:0]    exp_gnt [int];
  logic          exp_we  [int];
  logic [1:0]    exp_rid [int];
  logic [DW-1:0] exp_rd  [int];

  always @(posedge clk or posedge rst) begin
    int c;
    int win;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic we;
    if (rst) begin
      exp_gnt.delete(); exp_we.delete(); exp_rid.delete(); exp_rd.delete();
      gwait_m = 0; last_addr = '0; last_wdata = '0; wr_pend = 0;
      next_idle = cyc;
    end else begin
      c = cyc;
      if (wr_pend && wr_cyc == c) begin
        m_mem[wr_addr] = wr_data;
        wr_pend = 0;
      end
      if (c >= next_idle) begin
        win = 0;
        if (bus.g_req && gwait_m == LIMIT) win = 3;
        else if (bus.d_req) win = 2;
        else if (bus.f_req) win = 1;
        else if (bus.g_req) win = 3;
        if (!bus.g_req || win == 3) gwait_m = 0;
        else gwait_m = (gwait_m + 1 > LIMIT) ? LIMIT : gwait_m + 1;
        if (win != 0) begin
          case (win)
            1: begin a = bus.f_addr; we = 1'b0;     wd = '0;          end
            2: begin a = bus.d_addr; we = bus.d_we; wd = bus.d_wdata; end
            default: begin a = bus.g_addr; we = bus.g_we; wd = bus.g_wdata; end
          endcase
          last_addr = a;
          last_wdata = wd;
          exp_gnt[c+1] = 3'b001 << (win - 1);
          exp_we[c+1] = we;
          if (we) begin
            wr_pend = 1; wr_cyc = c + 1; wr_addr = a; wr_data = wd;
            next_idle = c + 2;
          end else begin
            exp_rid[c+2] = 2'(win);
            exp_rd[c+2] = m_mem[a];
            next_idle = c + 3;
          end
        end
      end
      cyc = c + 1;
    end
  end

  always @(negedge clk) begin
    int k;
    logic [2:0] eg;
    logic ewe;
    logic [1:0] erid;
    logic [2:0] g;
    g = {bus.g_gnt, bus.d_gnt, bus.f_gnt};
    if (rst) begin
      chk("rst_gnt", 32'(g), 0);
      chk("rst_rvalid", 32'(bus.rvalid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst_w_en", 32'(bus.mem_w_en), 0);
    end else begin
      k = cyc;
      eg   = exp_gnt.exists(k) ? exp_gnt[k] : 3'b000;
      ewe  = exp_we.exists(k) ? exp_we[k] : 1'b0;
      erid = exp_rid.exists(k) ? exp_rid[k] : 2'b00;
      chk("gnt", 32'(g), 32'(eg));
      chk("gnt_onehot", 32'($countones(g) <= 1), 1);
      chk("mem_w_en", 32'(bus.mem_w_en), 32'(ewe));
      chk("mem_addr", 32'(bus.mem_addr), 32'(last_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(last_wdata));
      chk("rvalid", 32'(bus.rvalid), 32'(erid != 2'b00));
      chk("rid", 32'(bus.rid), 32'(erid));
      if (erid != 2'b00) chk("rdata", 32'(bus.rdata), 32'(exp_rd[k]));
      chk("busy", 32'(bus.busy), 32'(k < next_idle));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    nstep++;
  endtask

  function automatic logic gnt_of(input int which);
    case (which)
      1: return bus.f_gnt;
      2: return bus.d_gnt;
      default: return bus.g_gnt;
    endcase
  endfunction

  task automatic wait_gnt(input int which);
    bit ok = 0;
    for (int i = 0; i < 12; i++) begin
      if (gnt_of(which)) begin ok = 1; break; end
      step();
    end
    chk("gnt_wait_budget", 32'(ok), 1);
  endtask

  task automatic count_losses(output int losses);
    losses = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.g_gnt) break;
      if (bus.d_gnt || bus.f_gnt) losses++;
    end
    chk("starve_g_gnt_seen", 32'(bus.g_gnt), 1);
  endtask

  initial begin
    int t0;
    int losses;
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int losses;
    for (int i = 0; i < 65536; i++) begin
      mem[i]   = 16'(i) ^ 16'h5A00;
      m_mem[i] = 16'(i) ^ 16'h5A00;
    end
    mem[16'h3000] = 16'h1234;
    m_mem[16'h3000] = 16'h1234;
    bus.f_req = 0; bus.f_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.g_req = 0; bus.g_we = 0; bus.g_addr = '0; bus.g_wdata = '0;

    step(); step();
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_rid", 32'(bus.rid), 0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 0);
    rst = 0;
    step();

    // Single fetch read.
    bus.f_req = 1; bus.f_addr = 16'h3000;
    step();
    chk("fetch_gnt", 32'(bus.f_gnt), 1);
    chk("fetch_mem_addr", 32'(bus.mem_addr), 32'h3000);
    chk("fetch_w_en", 32'(bus.mem_w_en), 0);
    bus.f_req = 0;
    step();
    chk("fetch_rvalid", 32'(bus.rvalid), 1);
    chk("fetch_rid", 32'(bus.rid), 1);
    chk("fetch_rdata", 32'(bus.rdata), 32'h1234);
    step();
    chk("fetch_done_busy", 32'(bus.busy), 0);

    // Data write beats a simultaneous fetch.
    bus.f_req = 1; bus.f_addr = 16'h3000;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h4000; bus.d_wdata = 16'hBEEF;
    step();
    chk("dw_d_gnt", 32'(bus.d_gnt), 1);
    chk("dw_f_gnt", 32'(bus.f_gnt), 0);
    chk("dw_w_en", 32'(bus.mem_w_en), 1);
    chk("dw_addr", 32'(bus.mem_addr), 32'h4000);
    chk("dw_wdata", 32'(bus.mem_wdata), 32'hBEEF);
    bus.d_req = 0;
    step();
    chk("dw_idle_w_en", 32'(bus.mem_w_en), 0);
    step();
    chk("dw_then_f_gnt", 32'(bus.f_gnt), 1);
    bus.f_req = 0;
    step(); step();

    // Back-to-back data reads.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0010;
    wait_gnt(2);
    t0 = nstep;
    bus.d_addr = 16'h0011;
    step();
    chk("b2b_rdata0", 32'(bus.rdata), 32'h5A10);
    chk("b2b_rid0", 32'(bus.rid), 2);
    step();
    wait_gnt(2);
    chk("b2b_gap", 32'(nstep - t0), 3);
    bus.d_req = 0;
    step();
    chk("b2b_rdata1", 32'(bus.rdata), 32'h5A11);
    step();

    // Debug starvation escape, twice to confirm the wait count clears on grant.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0020;
    bus.f_req = 1; bus.f_addr = 16'h0021;
    bus.g_req = 1; bus.g_we = 0; bus.g_addr = 16'h0022;
    count_losses(losses);
    chk("starve_losses_1", 32'(losses), LIMIT);
    count_losses(losses);
    chk("starve_losses_2", 32'(losses), LIMIT);
    bus.d_req = 0; bus.f_req = 0; bus.g_req = 0;
    step(); step(); step();

    // Reset in the middle of a read response.
    bus.f_req = 1; bus.f_addr = 16'h0030;
    wait_gnt(1);
    bus.f_req = 0;
    step();
    chk("rstmid_rvalid_before", 32'(bus.rvalid), 1);
    #2 rst = 1;
    #1;
    chk("rstmid_rvalid", 32'(bus.rvalid), 0);
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_rid", 32'(bus.rid), 0);
    chk("rstmid_rdata", 32'(bus.rdata), 0);
    step(); step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rstmid_no_rvalid", 32'(bus.rvalid), 0);
    end

    // Random traffic; each requester holds until granted, then may re-request at once.
    for (int it = 0; it < 3000; it++) begin
      step();
      if (it == 1500) begin
        rst = 1; step(); step(); rst = 0;
      end
      if (!bus.f_req || bus.f_gnt) begin
        bus.f_req = ($urandom_range(0, 9) < 5);
        bus.f_addr = 16'h0010 + 16'($urandom_range(0, 15));
      end
      if (!bus.d_req || bus.d_gnt) begin
        bus.d_req = ($urandom_range(0, 9) < 5);
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = 16'h0010 + 16'($urandom_range(0, 15));
        bus.d_wdata = 16'($urandom);
      end
      if (!bus.g_req || bus.g_gnt) begin
        bus.g_req = ($urandom_range(0, 9) < 4);
        bus.g_we = 1'($urandom_range(0, 1));
        bus.g_addr = 16'h0010 + 16'($urandom_range(0, 15));
        bus.g_wdata = 16'($urandom);
      end
    end
    bus.f_req = 0; bus.d_req = 0; bus.g_req = 0;
    for (int i = 0; i < 6; i++) step();
    chk("final_idle", 32'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/punc_mem_arbiter.md
PUNC_MEM_ARBITER -- requirements
Module: punc_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width.
REQ-002 Parameter DATA_W, default 16, data width.
REQ-003 Parameter STARVE_LIMIT, default 4, number of lost arbitrations after which debug wins.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 f_req  input  1  instruction-fetch read request; fetch never writes.
REQ-007 f_addr  input  ADDR_W  fetch address.
REQ-008 d_req, d_we  input  1 each  datapath (LD/LDI/LDR/ST/STI/STR) request; d_we=1 means write.
REQ-009 d_addr, d_wdata  input  ADDR_W, DATA_W  datapath address and write data.
REQ-010 g_req, g_we  input  1 each  debug/loader request; g_we=1 means write.
REQ-011 g_addr, g_wdata  input  ADDR_W, DATA_W  debug address and write data.
REQ-012 f_gnt, d_gnt, g_gnt  output  1 each  one-cycle grant pulse, asserted in the cycle the access is issued to memory.
REQ-013 rvalid  output  1  one-cycle read-data-valid pulse.
REQ-014 rid  output  2  owner of rvalid: 01 fetch, 10 data, 11 debug, 00 none.
REQ-015 rdata  output  DATA_W  read data, meaningful only while rvalid=1.
REQ-016 mem_addr, mem_wdata  output  ADDR_W, DATA_W  single-port memory address and write data.
REQ-017 mem_w_en  output  1  memory write enable.
REQ-018 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read address is presented.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP.
REQ-021 In IDLE with any req high, the block SHALL select a winner, latch its id/addr/we/wdata, and move to ACCESS next cycle.
REQ-022 IDLE with no req high: remain in IDLE.
REQ-023 Priority: debug if g_req=1 and g_wait==STARVE_LIMIT; otherwise data > fetch > debug.
REQ-024 g_wait: increments, saturating at STARVE_LIMIT, on each IDLE arbitration where g_req=1 and debug loses; clears to 0 on debug grant or whenever g_req=0 in IDLE.
REQ-025 ACCESS: drive mem_addr/mem_wdata from the latched registers; mem_w_en = latched we; pulse the winner's gnt for exactly one cycle.
REQ-026 ACCESS with a write: next state IDLE, no rvalid. Latency req->gnt is 1 cycle; a write occupies 2 cycles.
REQ-027 ACCESS with a read: next state RESP; in RESP, rvalid=1, rid=latched id, rdata=mem_rdata; then IDLE. A read occupies 3 cycles.
REQ-028 Requests are sampled only in IDLE; a requester SHALL hold req/addr/data until its gnt. Deasserting req after the latch does not cancel the access.
REQ-029 At most one gnt and at most one rvalid are high in any cycle; mem_w_en is 0 outside ACCESS.
REQ-030 mem_addr/mem_wdata hold their last latched value outside ACCESS.
REQ-031 Requests arriving in ACCESS/RESP wait for the next IDLE; no request is lost while held.

Reset
REQ-032 rst=1 SHALL immediately force IDLE; all gnt, rvalid, mem_w_en, busy = 0; rid = 00; rdata, mem_addr, mem_wdata = 0; g_wait = 0; latched registers = 0.
REQ-033 Reset during ACCESS or RESP SHALL abort the access and drop the pending response; no gnt or rvalid for it follows reset release.
REQ-034 The first arbitration occurs on the first posedge with rst=0.

Verification
REQ-035 f_req only, f_addr=0x3000, mem returns 0x1234 -> f_gnt cycle 1, rvalid/rid=01/rdata=0x1234 cycle 2, busy low cycle 3.
REQ-036 f_req and d_req (d_we=1, 0x4000, 0xBEEF) together -> d_gnt first with mem_w_en=1 and mem_addr=0x4000 for one cycle, then f_gnt two cycles later.
REQ-037 g_req held while d_req/f_req are continuously asserted, STARVE_LIMIT=4 -> g_gnt on the 5th arbitration, g_wait back to 0.
REQ-038 rst asserted mid-RESP -> outputs 0 asynchronously; no rvalid after release.
REQ-039 Back-to-back d_req reads to 0x0010, 0x0011 -> grants 3 cycles apart; rvalid pulses carry the matching data, never overlapping.
REQ-040 Random traffic on all three ports -> at most one gnt per cycle, rvalid only after a read gnt, and no held request is starved beyond STARVE_LIMIT+1 arbitrations for debug.
